// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM; `MIPS_CTRL_LOGICAL_IMM_EN adds andi/ori
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       ext_signed,
  output logic       illegal,
  output logic [3:0] state
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEXEC = 4'd6, S_ALUWB = 4'd7,
                         S_BEQ = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_JUMP = 4'd11,
                         S_ILLEGAL = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
  logic [5:0] op_q;
  logic [3:0] nxt, dec;
  logic       imm_ok, logic_imm;
  logic       pcw, irw, mr, mw, rw;
`ifdef MIPS_CTRL_LOGICAL_IMM_EN
  assign imm_ok    = opcode == OP_ADDI || opcode == OP_SLTI || opcode == OP_ANDI || opcode == OP_ORI;
  assign logic_imm = op_q == OP_ANDI || op_q == OP_ORI;
`else
  assign imm_ok    = opcode == OP_ADDI || opcode == OP_SLTI;
  assign logic_imm = 1'b0;
`endif
  assign dec = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
               opcode == OP_R   ? S_RTEXEC :
               opcode == OP_BEQ ? S_BEQ :
               opcode == OP_J   ? S_JUMP :
               imm_ok           ? S_IEXEC : S_ILLEGAL;
  // state register; opcode is captured once, in DECODE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) op_q <= opcode;
    end
  // next-state selection; memory states wait on mem_ready
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = dec;
      S_MEMADR: nxt = op_q == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC: nxt = S_ALUWB;
      S_IEXEC:  nxt = S_IWB;
      default:  nxt = S_FETCH;
    endcase
  end
  // Moore output decode; only FETCH and BEQ look at inputs
  always_comb begin
    pcw        = 1'b0;
    irw        = 1'b0;
    mr         = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    ext_signed = 1'b1;
    illegal    = 1'b0;
    case (state)
      S_FETCH:   begin mr = 1'b1; alu_src_b = 2'b01; irw = mem_ready; pcw = mem_ready; end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:   begin mr = 1'b1; iord = 1'b1; end
      S_MEMWB:   begin rw = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:   begin mw = 1'b1; iord = 1'b1; end
      S_RTEXEC:  begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_ALUWB:   begin rw = 1'b1; reg_dst = 1'b1; end
      S_BEQ:     begin alu_src_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; pcw = zero; end
      S_IEXEC:   begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = op_q == OP_ADDI ? 2'b00 : 2'b11;
        ext_signed = !logic_imm;
      end
      S_IWB:     begin rw = 1'b1; ext_signed = !logic_imm; end
      S_JUMP:    begin pc_src = 2'b10; pcw = 1'b1; end
      S_ILLEGAL: illegal = 1'b1;
      default:   ;
    endcase
  end
  assign pc_write  = pcw & rst_n;
  assign ir_write  = irw & rst_n;
  assign mem_read  = mr & rst_n;
  assign mem_write = mw & rst_n;
  assign reg_write = rw & rst_n;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random instruction stream checked against a per-instruction cycle model
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_signed, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [20:0] obs;
  int errs = 0, checks = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .ext_signed(ext_signed), .illegal(illegal), .state(state)
  );

  assign obs = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src, ext_signed, illegal, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input int st, pcw, irw, mr, mw, io, rw, rd, m2r, asa,
                                     asb, aop, psrc, ext, ill);
    return {1'(pcw), 1'(irw), 1'(mr), 1'(mw), 1'(io), 1'(rw), 1'(rd), 1'(m2r), 1'(asa),
            2'(asb), 2'(aop), 2'(psrc), 1'(ext), 1'(ill), 4'(st)};
  endfunction

  // instruction classes: 0 mem, 1 R-type, 2 beq, 3 j, 4 immediate ALU, 5 unsupported
  function automatic int cls(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 0;
    if (op == OP_R) return 1;
    if (op == OP_BEQ) return 2;
    if (op == OP_J) return 3;
    if (op == OP_ADDI || op == OP_SLTI) return 4;
`ifdef MIPS_CTRL_LOGICAL_IMM_EN
    if (op == OP_ANDI || op == OP_ORI) return 4;
`endif
    return 5;
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nxt(input logic mr, input logic [5:0] op);
    @(negedge clk);
    mem_ready = mr;
    zero      = 1'($urandom);
    opcode    = op;
    #1;
  endtask

  task automatic run(input logic [5:0] op);
    int n, c;
    logic r, ext;
    logic [1:0] aop;
    c = cls(op);
    n = 0;
    do begin
      r = ($urandom_range(0, 2) != 0) || n >= 4;
      n++;
      nxt(r, 6'($urandom));
      check("fetch", obs, mk(0, r, r, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    end while (!r);
    nxt(1'($urandom), op);
    check("decode", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
    case (c)
      0: begin
        nxt(1'($urandom), 6'($urandom));
        check("memadr", obs, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
        n = 0;
        do begin
          r = ($urandom_range(0, 2) != 0) || n >= 4;
          n++;
          nxt(r, 6'($urandom));
          if (op == OP_LW) check("memrd", obs, mk(3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
          else             check("memwr", obs, mk(5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end while (!r);
        if (op == OP_LW) begin
          nxt(1'($urandom), 6'($urandom));
          check("memwb", obs, mk(4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        end
      end
      1: begin
        nxt(1'($urandom), 6'($urandom));
        check("rtexec", obs, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0));
        nxt(1'($urandom), 6'($urandom));
        check("aluwb", obs, mk(7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
      end
      2: begin
        nxt(1'($urandom), 6'($urandom));
        check("beq", obs, mk(8, zero, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
      end
      3: begin
        nxt(1'($urandom), 6'($urandom));
        check("jump", obs, mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
      end
      4: begin
        ext = !(op == OP_ANDI || op == OP_ORI);
        aop = op == OP_ADDI ? 2'b00 : 2'b11;
        nxt(1'($urandom), 6'($urandom));
        check("iexec", obs, mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, aop, 0, ext, 0));
        nxt(1'($urandom), 6'($urandom));
        check("iwb", obs, mk(10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ext, 0));
      end
      default: begin
        nxt(1'($urandom), 6'($urandom));
        check("illegal", obs, mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      end
    endcase
  endtask

  initial begin
    logic [5:0] dir [11];
    logic [5:0] legal [9];
    dir   = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, 6'h3f};
    legal = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    opcode = '0;
    #3;
    check("reset", obs, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    foreach (dir[i]) run(dir[i]);
    for (int i = 0; i < 80; i++)
      run($urandom_range(0, 1) ? legal[$urandom_range(0, 8)] : 6'($urandom));
    nxt(1'b1, 6'($urandom));
    check("fetch", obs, mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    nxt(1'b0, OP_SW);
    check("decode", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
    nxt(1'b0, 6'($urandom));
    check("memadr", obs, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    nxt(1'b0, 6'($urandom));
    check("memwr", obs, mk(5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_abort", obs, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_fetch", obs, mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    nxt(1'b1, OP_J);
    check("decode", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
    nxt(1'b1, 6'($urandom));
    check("jump", obs, mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    run(OP_LW);
    run(OP_ORI);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
